// File: rtl/console_pkg.sv
// Shared widths, FSM state encoding and the run-stop helper for the operator console.
package console_pkg;

  localparam int WORD_W = 31;
  localparam int ADDR_W = 12;
  localparam int OPC_W  = 6;
  localparam int PCNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_ADDR = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_MEM_WAIT = 3'd4
  } state_t;

  // Machine halts after an instruction when auto is off or the stop address is reached.
  function automatic logic run_should_stop(input logic auto_en, input logic stop_en,
                                           input logic [ADDR_W-1:0] cur_addr,
                                           input logic [ADDR_W-1:0] stop_addr);
    return (!auto_en) || (stop_en && (cur_addr == stop_addr));
  endfunction

endpackage

// File: rtl/panel_debounce.sv
// Button debouncer: accepts a new level after DEBOUNCE_CYCLES consecutive differing samples,
// emitting a one-cycle pulse when the accepted level rises.
module panel_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic pulse
);

  logic        level;
  logic [15:0] count;

  // Count differing samples; flip the accepted level once the run is long enough.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      level <= 1'b0;
      count <= 16'd0;
      pulse <= 1'b0;
    end else if (raw == level) begin
      count <= 16'd0;
      pulse <= 1'b0;
    end else if (count == (DEBOUNCE_CYCLES - 16'd1)) begin
      level <= raw;
      count <= 16'd0;
      pulse <= raw;
    end else begin
      count <= count + 16'd1;
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/console_panel.sv
// Operator console front end: debounced buttons, register load/clear decode, manual memory
// sequencing, run control with stop-at-address, and registered light outputs.
module console_panel
  import console_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              btn_machine_start,
  input  logic              btn_clear_pulse,
  input  logic              btn_do_read_mem,
  input  logic              btn_do_write_mem,
  input  logic              btn_write_reg,
  input  logic              btn_clear_reg_c,
  input  logic              btn_clear_reg_select,
  input  logic              btn_clear_reg_start,
  input  logic              switch_auto_enable,
  input  logic              switch_stop_at_enable,
  input  logic              switch_select_or_start,
  input  logic              switch_arr_reg_c,
  input  logic              switch_arr_reg_select,
  input  logic              switch_arr_reg_start,
  input  logic [WORD_W-1:0] input_reg_c_value,
  input  logic [ADDR_W-1:0] input_reg_select_value,
  input  logic [ADDR_W-1:0] input_reg_start_value,
  input  logic              instr_done,
  input  logic              mem_finish,
  input  logic [WORD_W-1:0] reg_c_value,
  input  logic [ADDR_W-1:0] reg_select_value,
  input  logic [ADDR_W-1:0] reg_start_value,
  input  logic [OPC_W-1:0]  op_code_value,
  input  logic [PCNT_W-1:0] pulse_counter_value,
  output logic              machine_start_pulse,
  output logic              clear_pulse,
  output logic              do_arr_reg_c,
  output logic [WORD_W-1:0] arr_reg_c_data,
  output logic              do_arr_reg_select,
  output logic [ADDR_W-1:0] arr_reg_select_data,
  output logic              do_arr_reg_start,
  output logic [ADDR_W-1:0] arr_reg_start_data,
  output logic              do_start_to_select,
  output logic              mem_read_pulse,
  output logic              mem_write_pulse,
  output logic              running,
  output logic [WORD_W-1:0] light_reg_c_value,
  output logic [ADDR_W-1:0] light_reg_select_value,
  output logic [ADDR_W-1:0] light_reg_start_value,
  output logic [OPC_W-1:0]  light_op_code_value,
  output logic [PCNT_W-1:0] light_pulse_counter_value
);

  logic [7:0] raw_btn;
  logic [7:0] btn;

  assign raw_btn = {btn_clear_reg_start, btn_clear_reg_select, btn_clear_reg_c, btn_write_reg,
                    btn_do_write_mem, btn_do_read_mem, btn_clear_pulse, btn_machine_start};

  for (genvar gi = 0; gi < 8; gi++) begin : g_deb
    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .resetn (resetn),
      .raw    (raw_btn[gi]),
      .pulse  (btn[gi])
    );
  end

  state_t              state, state_next;
  logic                op_write, op_write_next;
  logic                start_n, clear_n, rd_n, wr_n, sts_n;
  logic                c_n, sel_n, st_n;
  logic [WORD_W-1:0]   c_data_n;
  logic [ADDR_W-1:0]   sel_data_n, st_data_n;

  // Next-state and next-output decode; the clear button overrides the whole sequencer.
  always_comb begin
    state_next    = state;
    op_write_next = op_write;
    start_n       = 1'b0;
    clear_n       = 1'b0;
    rd_n          = 1'b0;
    wr_n          = 1'b0;
    sts_n         = 1'b0;
    c_n           = 1'b0;
    sel_n         = 1'b0;
    st_n          = 1'b0;
    c_data_n      = {WORD_W{1'b0}};
    sel_data_n    = {ADDR_W{1'b0}};
    st_data_n     = {ADDR_W{1'b0}};
    if (btn[1]) begin
      clear_n    = 1'b1;
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (btn[0]) begin
            start_n    = 1'b1;
            state_next = ST_RUN;
          end else if (btn[2]) begin
            op_write_next = 1'b0;
            state_next    = ST_MEM_ADDR;
          end else if (btn[3]) begin
            op_write_next = 1'b1;
            state_next    = ST_MEM_ADDR;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!instr_done) begin
            state_next = ST_RUN;
          end else if (run_should_stop(switch_auto_enable, switch_stop_at_enable,
                                       reg_start_value, input_reg_start_value)) begin
            state_next = ST_IDLE;
          end else begin
            start_n = 1'b1;
          end
        end
        ST_MEM_ADDR: begin
          if (switch_select_or_start) begin
            sel_n      = 1'b1;
            sel_data_n = input_reg_select_value;
          end else begin
            sts_n = 1'b1;
          end
          state_next = ST_MEM_REQ;
        end
        ST_MEM_REQ: begin
          if (op_write) begin
            wr_n = 1'b1;
          end else begin
            rd_n = 1'b1;
          end
          state_next = ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          if (mem_finish) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_MEM_WAIT;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
    // Register buttons only matter while idle; a clear beats a write on the same register.
    if (state == ST_IDLE) begin
      c_n  = btn[5] || (btn[4] && switch_arr_reg_c);
      st_n = btn[7] || (btn[4] && switch_arr_reg_start);
      if (btn[6] || (btn[4] && switch_arr_reg_select)) begin
        sel_n = 1'b1;
      end else begin
        sel_n = sel_n;
      end
      c_data_n  = (!btn[5] && btn[4] && switch_arr_reg_c)     ? input_reg_c_value     : {WORD_W{1'b0}};
      st_data_n = (!btn[7] && btn[4] && switch_arr_reg_start) ? input_reg_start_value : {ADDR_W{1'b0}};
      if (!btn[6] && btn[4] && switch_arr_reg_select) begin
        sel_data_n = input_reg_select_value;
      end else begin
        sel_data_n = sel_data_n;
      end
    end else begin
      c_n = 1'b0;
    end
  end

  // State register plus registered pulses and lights.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                     <= ST_IDLE;
      op_write                  <= 1'b0;
      machine_start_pulse       <= 1'b0;
      clear_pulse               <= 1'b0;
      do_arr_reg_c              <= 1'b0;
      arr_reg_c_data            <= {WORD_W{1'b0}};
      do_arr_reg_select         <= 1'b0;
      arr_reg_select_data       <= {ADDR_W{1'b0}};
      do_arr_reg_start          <= 1'b0;
      arr_reg_start_data        <= {ADDR_W{1'b0}};
      do_start_to_select        <= 1'b0;
      mem_read_pulse            <= 1'b0;
      mem_write_pulse           <= 1'b0;
      running                   <= 1'b0;
      light_reg_c_value         <= {WORD_W{1'b0}};
      light_reg_select_value    <= {ADDR_W{1'b0}};
      light_reg_start_value     <= {ADDR_W{1'b0}};
      light_op_code_value       <= {OPC_W{1'b0}};
      light_pulse_counter_value <= {PCNT_W{1'b0}};
    end else begin
      state                     <= state_next;
      op_write                  <= op_write_next;
      machine_start_pulse       <= start_n;
      clear_pulse               <= clear_n;
      do_arr_reg_c              <= c_n;
      arr_reg_c_data            <= c_data_n;
      do_arr_reg_select         <= sel_n;
      arr_reg_select_data       <= sel_data_n;
      do_arr_reg_start          <= st_n;
      arr_reg_start_data        <= st_data_n;
      do_start_to_select        <= sts_n;
      mem_read_pulse            <= rd_n;
      mem_write_pulse           <= wr_n;
      running                   <= (state_next == ST_RUN);
      light_reg_c_value         <= reg_c_value;
      light_reg_select_value    <= reg_select_value;
      light_reg_start_value     <= reg_start_value;
      light_op_code_value       <= op_code_value;
      light_pulse_counter_value <= pulse_counter_value;
    end
  end

endmodule
